// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle CPU control path.
// Holds the instruction class codes (opcode[15:12]), the ALU operation
// codes, the control-unit run-state enum and the decoded strobe bundle
// that passes between uc_decode and uc.
package cpu_pkg;

    // Instruction classes, taken from opcode[15:12]
    localparam logic [3:0] CLS_NOP   = 4'h0;
    localparam logic [3:0] CLS_ALU   = 4'h1;
    localparam logic [3:0] CLS_LOADI = 4'h2;
    localparam logic [3:0] CLS_JMP   = 4'h3;
    localparam logic [3:0] CLS_JZ    = 4'h4;
    localparam logic [3:0] CLS_JNZ   = 4'h5;
    localparam logic [3:0] CLS_JC    = 4'h6;
    localparam logic [3:0] CLS_JNC   = 4'h7;
    localparam logic [3:0] CLS_CALL  = 4'h8;
    localparam logic [3:0] CLS_RET   = 4'h9;
    localparam logic [3:0] CLS_HALT  = 4'hF;

    // ALU operation codes
    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_NOT_A  = 3'b001;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_OR     = 3'b101;
    localparam logic [2:0] ALU_NEG_A  = 3'b110;
    localparam logic [2:0] ALU_NEG_B  = 3'b111;

    // Control-unit run state
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        HALT  = 2'b01,
        FAULT = 2'b10
    } state_t;

    // Raw strobes produced by the class decoder, before state/depth gating
    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic       push;
        logic       pop;
        logic [2:0] op_alu;
        logic       illegal;
        logic       is_halt;
    } strobes_t;

    // Extract the instruction class from a 16-bit opcode
    function automatic logic [3:0] class_of(input logic [15:0] opcode);
        return opcode[15:12];
    endfunction

endpackage

// File: rtl/uc_decode.sv
// Purely combinational class decoder for the control unit.
// Ports:
//   cls    in  4 : instruction class (opcode[15:12])
//   alu_fn in  3 : ALU function field (opcode[11:9])
//   z      in  1 : registered zero flag
//   carry  in  1 : registered carry flag
//   strb   out   : raw strobe bundle, not yet gated by run state or depth
module uc_decode
    import cpu_pkg::*;
(
    input  logic [3:0] cls,
    input  logic [2:0] alu_fn,
    input  logic       z,
    input  logic       carry,
    output strobes_t   strb
);

    // Map class and flags to the raw datapath strobes
    always_comb begin
        strb = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0,
                 push: 1'b0, pop: 1'b0, op_alu: ALU_PASS_A,
                 illegal: 1'b0, is_halt: 1'b0};
        case (cls)
            CLS_NOP: begin
                strb.s_inc = 1'b1;
            end
            CLS_ALU: begin
                strb.we3    = 1'b1;
                strb.wez    = 1'b1;
                strb.op_alu = alu_fn;
            end
            CLS_LOADI: begin
                strb.we3    = 1'b1;
                strb.s_inm  = 1'b1;
                strb.op_alu = ALU_PASS_A;
            end
            CLS_JMP:  strb.s_inc = 1'b0;
            // A taken jump selects the target, so s_inc is the inverted condition
            CLS_JZ:   strb.s_inc = ~z;
            CLS_JNZ:  strb.s_inc = z;
            CLS_JC:   strb.s_inc = ~carry;
            CLS_JNC:  strb.s_inc = carry;
            CLS_CALL: begin
                strb.push  = 1'b1;
                strb.s_inc = 1'b0;
            end
            CLS_RET: begin
                strb.pop = 1'b1;
            end
            CLS_HALT: begin
                // Target field holds the HALT's own address, so the PC self-loops
                strb.s_inc   = 1'b0;
                strb.is_halt = 1'b1;
            end
            default: begin
                // Classes A..E: behave as NOP and flag the illegal opcode
                strb.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uc.sv
// Control unit for the single-cycle CPU.
// Decodes opcode plus the datapath's registered z/carry flags into same-cycle
// control strobes, and tracks run state (RUN/HALT/FAULT), call depth with
// overflow/underflow detection, and a retired-instruction counter.
// Ports:
//   clk, reset (async, active low)
//   opcode[15:0], z, carry          : inputs from the datapath
//   s_inc, s_inm, we3, wez, push,
//   pop, op_alu[2:0], illegal       : combinational strobes
//   halted, fault                   : run state flags (from state register)
//   depth[DW-1:0], icount[15:0]     : call depth, retired-instruction count
module uc
    import cpu_pkg::*;
#(
    parameter int STACK_DEPTH = 16,
    localparam int DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   opcode,
    input  logic          z,
    input  logic          carry,
    output logic          s_inc,
    output logic          s_inm,
    output logic          we3,
    output logic          wez,
    output logic          push,
    output logic          pop,
    output logic [2:0]    op_alu,
    output logic          halted,
    output logic          fault,
    output logic          illegal,
    output logic [DW-1:0] depth,
    output logic [15:0]   icount
);

    localparam logic [DW-1:0] DEPTH_MAX  = DW'(STACK_DEPTH);
    localparam logic [DW-1:0] DEPTH_ZERO = {DW{1'b0}};
    localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);

    state_t        state_r;
    logic [DW-1:0] depth_r;
    logic [15:0]   icount_r;
    strobes_t      raw_s;
    logic          run_s;
    logic          overflow_s;
    logic          underflow_s;
    logic          fault_cyc_s;
    logic          unused_s;

    // Operand/immediate bits are consumed by the datapath, not here
    assign unused_s = ^opcode[8:0];

    uc_decode u_decode (
        .cls    (class_of(opcode)),
        .alu_fn (opcode[11:9]),
        .z      (z),
        .carry  (carry),
        .strb   (raw_s)
    );

    assign run_s       = (state_r == RUN);
    assign overflow_s  = run_s && raw_s.push && (depth_r == DEPTH_MAX);
    assign underflow_s = run_s && raw_s.pop  && (depth_r == DEPTH_ZERO);
    assign fault_cyc_s = overflow_s || underflow_s;

    // Gate the raw strobes by reset, run state and stack-bound faults
    always_comb begin
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        we3     = 1'b0;
        wez     = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        op_alu  = ALU_PASS_A;
        illegal = 1'b0;
        if (!reset) begin
            // Reset overrides decode even though opcode may be live
            s_inc = 1'b1;
        end else if (!run_s) begin
            // HALT/FAULT (or a corrupted state): freeze the PC, no side effects
            s_inc = 1'b0;
        end else if (fault_cyc_s) begin
            s_inc = 1'b0;
        end else begin
            s_inc   = raw_s.s_inc;
            s_inm   = raw_s.s_inm;
            we3     = raw_s.we3;
            wez     = raw_s.wez;
            push    = raw_s.push;
            pop     = raw_s.pop;
            op_alu  = raw_s.op_alu;
            illegal = raw_s.illegal;
        end
    end

    // Run-state FSM with call-depth tracking and retired-instruction count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= RUN;
            depth_r  <= DEPTH_ZERO;
            icount_r <= 16'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (fault_cyc_s) begin
                        state_r <= FAULT;
                    end else begin
                        icount_r <= icount_r + 16'd1;
                        state_r  <= raw_s.is_halt ? HALT : RUN;
                        if (raw_s.push) begin
                            depth_r <= depth_r + DEPTH_ONE;
                        end else if (raw_s.pop) begin
                            depth_r <= depth_r - DEPTH_ONE;
                        end else begin
                            depth_r <= depth_r;
                        end
                    end
                end
                HALT:    state_r <= HALT;
                FAULT:   state_r <= FAULT;
                default: state_r <= FAULT;
            endcase
        end
    end

    assign halted = (state_r == HALT);
    assign fault  = (state_r == FAULT);
    assign depth  = depth_r;
    assign icount = icount_r;

endmodule

// File: tb/tb_uc.sv
// Scoreboard testbench for uc: a stimulus process drives inputs on the falling
// edge and queues the expected outputs computed by a behavioural model; a
// monitor samples the DUT shortly afterwards and compares against the queue.
module tb_uc;

    localparam int SD = 16;
    localparam int DW = $clog2(SD + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   opcode;
    logic          z;
    logic          carry;
    logic          s_inc, s_inm, we3, wez, push, pop, halted, fault, illegal;
    logic [2:0]    op_alu;
    logic [DW-1:0] depth;
    logic [15:0]   icount;

    uc #(.STACK_DEPTH(SD)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .carry(carry),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .push(push),
        .pop(pop), .op_alu(op_alu), .halted(halted), .fault(fault),
        .illegal(illegal), .depth(depth), .icount(icount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] v;
        string       nm;
    } exp_t;

    exp_t sb_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    // Model state: 0 running, 1 halted, 2 faulted
    int m_st = 0;
    int m_depth = 0;
    int m_ic = 0;

    // Apply one cycle of stimulus and queue what the specification predicts
    task automatic step(input logic [15:0] op, input logic zz, input logic cc,
                        input logic rst, input string nm);
        int   cls;
        logic e_inc, e_inm, e_we3, e_wez, e_push, e_pop, e_ill;
        logic [2:0] e_alu;
        exp_t e;
        @(negedge clk);
        opcode = op; z = zz; carry = cc; reset = rst;
        cls = int'(op[15:12]);
        e_inc = 1'b1; e_inm = 1'b0; e_we3 = 1'b0; e_wez = 1'b0;
        e_push = 1'b0; e_pop = 1'b0; e_ill = 1'b0; e_alu = 3'b000;
        if (!rst) begin
            m_st = 0; m_depth = 0; m_ic = 0;
        end else if (m_st != 0) begin
            e_inc = 1'b0;
        end else if ((cls == 8 && m_depth == SD) || (cls == 9 && m_depth == 0)) begin
            e_inc = 1'b0;
        end else begin
            if (cls == 1) begin e_we3 = 1'b1; e_wez = 1'b1; e_alu = op[11:9]; end
            if (cls == 2) begin e_we3 = 1'b1; e_inm = 1'b1; end
            if (cls == 3 || cls == 8 || cls == 15) e_inc = 1'b0;
            if (cls == 4) e_inc = !zz;
            if (cls == 5) e_inc = zz;
            if (cls == 6) e_inc = !cc;
            if (cls == 7) e_inc = cc;
            if (cls == 8) e_push = 1'b1;
            if (cls == 9) e_pop = 1'b1;
            if (cls >= 10 && cls <= 14) e_ill = 1'b1;
        end
        e.v = {e_inc, e_inm, e_we3, e_wez, e_push, e_pop, e_alu, e_ill,
               (m_st == 1), (m_st == 2), 5'(m_depth), 16'(m_ic)};
        e.nm = nm;
        sb_q.push_back(e);
        // Advance the model to the state after the coming rising edge
        if (rst && m_st == 0) begin
            if ((cls == 8 && m_depth == SD) || (cls == 9 && m_depth == 0)) begin
                m_st = 2;
            end else begin
                m_ic = (m_ic + 1) % 65536;
                if (cls == 8) m_depth = m_depth + 1;
                if (cls == 9) m_depth = m_depth - 1;
                if (cls == 15) m_st = 1;
            end
        end
    endtask

    // Monitor: compare every queued expectation with the sampled outputs
    initial begin
        exp_t        e;
        logic [32:0] act;
        forever begin
            @(negedge clk);
            #2;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act = {s_inc, s_inm, we3, wez, push, pop, op_alu, illegal,
                       halted, fault, 5'(depth), icount};
                total_cnt++;
                if (act === e.v) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL %s: got %h expected %h (t=%0t)", e.nm, act, e.v, $time);
                end
            end
        end
    end

    function automatic logic [15:0] rnd_op(input int cls);
        logic [11:0] lo;
        lo = 12'($urandom);
        return {4'(cls), lo};
    endfunction

    initial begin
        reset = 1'b0; opcode = 16'h0000; z = 1'b0; carry = 1'b0;

        // Reset hold with a live ALU opcode, then release into that same opcode
        step(16'h1A00, 1'b1, 1'b1, 1'b0, "reset_hold");
        step(16'h1A00, 1'b1, 1'b1, 1'b0, "reset_hold2");
        step(16'h1A00, 1'b0, 1'b0, 1'b1, "release_alu");
        step(16'h0000, 1'b0, 1'b0, 1'b1, "icount_one");

        // Conditional jumps
        step(16'h4000, 1'b1, 1'b0, 1'b1, "jz_taken");
        step(16'h4000, 1'b0, 1'b0, 1'b1, "jz_not_taken");
        step(16'h5000, 1'b0, 1'b0, 1'b1, "jnz_taken");
        step(16'h6000, 1'b0, 1'b1, 1'b1, "jc_taken");
        step(16'h7000, 1'b0, 1'b0, 1'b1, "jnc_taken");
        step(16'h7000, 1'b0, 1'b1, 1'b1, "jnc_not_taken");
        step(16'h2123, 1'b0, 1'b0, 1'b1, "loadi");
        step(16'h3055, 1'b0, 1'b0, 1'b1, "jmp");

        // Stack overflow after 16 nested calls
        for (int i = 0; i < SD; i++) step(16'h8010, 1'b0, 1'b0, 1'b1, "call_fill");
        step(16'h8010, 1'b0, 1'b0, 1'b1, "call_overflow");
        step(16'h1A00, 1'b0, 1'b0, 1'b1, "after_overflow");
        step(16'h9000, 1'b0, 1'b0, 1'b1, "ret_in_fault");

        // Underflow on RET at depth 0
        step(16'h0000, 1'b0, 1'b0, 1'b0, "reset_mid_fault");
        step(16'h9000, 1'b0, 1'b0, 1'b1, "ret_underflow");
        step(16'h1A00, 1'b0, 1'b0, 1'b1, "alu_in_fault");

        // Call then return, then HALT and opcodes afterward
        step(16'h0000, 1'b0, 1'b0, 1'b0, "reset_again");
        step(16'h8020, 1'b0, 1'b0, 1'b1, "call_one");
        step(16'h9000, 1'b0, 1'b0, 1'b1, "ret_one");
        step(16'hF003, 1'b0, 1'b0, 1'b1, "halt");
        for (int i = 0; i < 6; i++)
            step(rnd_op($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'b1, "in_halt");

        // Illegal opcode
        step(16'h0000, 1'b0, 1'b0, 1'b0, "reset_mid_halt");
        step(16'hB000, 1'b0, 1'b0, 1'b1, "illegal");
        step(16'h0000, 1'b0, 1'b0, 1'b1, "after_illegal");

        // Random stream with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic r;
            r = !((m_st != 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0);
            step(rnd_op($urandom_range(0, 15)), 1'($urandom), 1'($urandom), r, "random");
        end

        // Counter wrap: 65535 non-faulting instructions, then an illegal one
        step(16'h0000, 1'b0, 1'b0, 1'b0, "reset_wrap");
        for (int i = 0; i < 65535; i++)
            step(rnd_op($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'b1, "wrap_fill");
        step(16'hB000, 1'b0, 1'b0, 1'b1, "illegal_at_ffff");
        step(16'h0000, 1'b0, 1'b0, 1'b1, "icount_wrapped");

        // Let the monitor drain, bounded
        repeat (3) @(negedge clk);
        #4;
        if (sb_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uc.md
# uc

Control unit for the single-cycle CPU. It decodes the 16-bit `opcode` and the registered `z`/`carry` flags presented by the datapath (`cd`), and drives the datapath control strobes in the same cycle. It also tracks run state (RUN/HALT/FAULT), call-stack depth for overflow and underflow detection, and a retired-instruction count. It is instantiated beside `cd` in the CPU top level.

## Interface
- `STACK_DEPTH`, 16: number of return-address entries in the datapath stack.
- `DW`, `$clog2(STACK_DEPTH+1)`: width of `depth` (localparam).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in 16: `INST[31:16]` from the datapath.
- `z` in 1: zero flag, registered in the datapath.
- `carry` in 1: carry flag, registered in the datapath.
- `s_inc` out 1: 1 selects PC+1, 0 selects the jump target `INST[9:0]`.
- `s_inm` out 1: 1 selects the immediate as ALU operand A.
- `we3` out 1: register-file write enable.
- `wez` out 1: flag register write enable.
- `push` out 1: push PC+1 onto the stack.
- `pop` out 1: select the stack top as next PC, and pop.
- `op_alu` out 3: ALU operation.
- `halted` out 1: state is HALT.
- `fault` out 1: state is FAULT.
- `illegal` out 1: one-cycle pulse when an undefined class is decoded in RUN.
- `depth` out DW: current call depth.
- `icount` out 16: retired-instruction counter.

## Operation
- Class is `opcode[15:12]`.
- 0 NOP: all enables 0, `s_inc`=1.
- 1 ALU: `we3`=`wez`=1, `s_inm`=0, `op_alu`=`opcode[11:9]`, `s_inc`=1.
- 2 LOADI: `we3`=1, `s_inm`=1, `op_alu`=ALU_PASS_A (3'b000), `wez`=0, `s_inc`=1.
- 3 JMP: `s_inc`=0.
- 4 JZ / 5 JNZ / 6 JC / 7 JNC: `s_inc` = ~cond. The conditions are z, ~z, carry, ~carry respectively.
- 8 CALL: `push`=1, `s_inc`=0, `depth`+1.
- 9 RET: `pop`=1, `depth`-1.
- F HALT: `s_inc`=0, next state HALT. The assembler encodes the instruction's own address in `INST[9:0]`, so the PC self-loops.
- A–E: treated as NOP, `illegal` pulses for that cycle, state stays RUN.
- `op_alu` = 0 for every class except ALU and LOADI.

States:
- RUN: decode as above.
- HALT: `we3`=`wez`=`push`=`pop`=0, `s_inc`=0. Exit only by reset.
- FAULT: same outputs as HALT. Exit only by reset.

Fault conditions:
- CALL with `depth`==STACK_DEPTH (overflow).
- RET with `depth`==0 (underflow).
- On the faulting cycle, `push`/`pop`/`we3`/`wez` are suppressed, `s_inc`=0, `depth` is unchanged, and next state is FAULT.

Counting:
- `icount` +1 on every RUN cycle that is not a fault cycle. This includes the HALT instruction itself and illegal opcodes.
- `icount` wraps 16'hFFFF→0.
- `depth` never changes outside RUN.

While `reset` is low:
- state RUN, `depth`=0, `icount`=0.
- Outputs: `s_inc`=1, `s_inm`=0, `we3`=`wez`=`push`=`pop`=0, `op_alu`=0, `halted`=`fault`=`illegal`=0.

## Timing
- All strobes (`s_inc`, `s_inm`, `we3`, `wez`, `push`, `pop`, `op_alu`, `illegal`) are combinational from `opcode`, `z`, `carry`, state and `depth`. This is zero latency, as the single-cycle datapath requires.
- `z`/`carry` reflect the most recent `wez` cycle. For ALU followed by JZ, the jump uses the ALU result's flag.
- State, `depth` and `icount` update on the rising `clk` edge. `halted`/`fault` assert the cycle after HALT or the faulting instruction.
- Reset assertion takes effect asynchronously. Deassertion is sampled at the next `clk` edge, and the first RUN decode happens in that cycle.
- Reset mid-CALL or mid-HALT discards all state.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode class localparams (CLS_NOP … CLS_HALT);
  - ALU op codes, including ALU_PASS_A;
  - state enum RUN/HALT/FAULT.
- One combinational sub-module `uc_decode` maps (class, z, carry) to the raw strobes.
- `uc` adds the FSM, the depth and fault gating, and `icount`.

## Test plan
- Reset low with opcode 16'h1A00 → all enables 0 and `s_inc`=1. Release reset → `we3`=`wez`=1, `op_alu`=3'b101, `icount`=1 after the edge.
- JZ (16'h4000) with z=1 → `s_inc`=0. With z=0 → `s_inc`=1. Same check for JNC with carry=0 → `s_inc`=0.
- 16 consecutive CALLs → `depth`=16 and `push` high each cycle. 17th CALL → `push`=0, `fault`=1 next cycle, `depth` stays 16.
- RET at `depth`=0 → `pop`=0, `fault`=1 next cycle. A subsequent ALU opcode → `we3`=0.
- HALT (16'hF000) → `halted`=1 next cycle, `icount` frozen, and enables stay 0 under any opcode until reset.
- Opcode 16'hB000 → `illegal` one-cycle pulse, all enables 0, state RUN. `icount` preloaded to 16'hFFFF wraps to 0.
